// File: rtl/down_timer.sv
`default_nettype none
// ============================================================================
// Module      : down_timer
// Description : Loadable down-counter / interval timer. Counts a programmed
//               interval N down to zero and emits a one-cycle terminal-count
//               pulse. One-shot mode stops at zero; periodic mode reloads
//               the interval and keeps running.
// Ports       : clk       rising-edge clock
//               rst_n     asynchronous active-low reset
//               i_load    load i_data into count and reload registers
//                         (takes effect regardless of i_enable)
//               i_enable  count enable; low holds all state
//               i_mode    0 = one-shot, 1 = periodic (auto-reload)
//               i_data    interval value N
//               o_count   current count (registered)
//               o_tc      terminal-count pulse (registered, one cycle)
//               o_busy    high while the timer is running
// Revision    : 1.0 - initial release
// ============================================================================
module down_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic             i_enable,
    input  logic             i_mode,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_count,
    output logic             o_tc,
    output logic             o_busy
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    localparam logic [WIDTH-1:0] c_ZERO = '0;
    localparam logic [WIDTH-1:0] c_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [0:0]       r_state;
    logic [0:0]       w_state_nxt;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_reload;
    logic             r_tc;
    logic [WIDTH-1:0] w_count_nxt;
    logic             w_step;
    logic             w_term;

    // An enabled edge while running either decrements or hits terminal count.
    assign w_step = (r_state == S_RUN) && i_enable;
    assign w_term = w_step && (r_count == c_ONE);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. LOAD has priority over the terminal event; a
    // zero load parks the timer in IDLE since there is nothing to count.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        if (i_load) begin
            w_state_nxt = (i_data != c_ZERO) ? S_RUN : S_IDLE;
        end else if (w_term && !i_mode) begin
            w_state_nxt = S_IDLE;
        end
    end

    // ------------------------------------------------------------------
    // Output decode from registered state
    // ------------------------------------------------------------------
    always_comb begin
        o_busy = (r_state == S_RUN);
    end

    // ------------------------------------------------------------------
    // Count datapath. Periodic mode reloads at the terminal event so
    // the count never shows zero while auto-reloading.
    // ------------------------------------------------------------------
    always_comb begin
        w_count_nxt = r_count;
        if (i_load) begin
            w_count_nxt = i_data;
        end else if (w_term) begin
            w_count_nxt = i_mode ? r_reload : c_ZERO;
        end else if (w_step) begin
            w_count_nxt = r_count - c_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count  <= '0;
            r_reload <= '0;
            r_tc     <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            if (i_load) begin
                r_reload <= i_data;
            end
            // A coincident LOAD suppresses the pulse.
            r_tc <= w_term && !i_load;
        end
    end

    assign o_count = r_count;
    assign o_tc    = r_tc;

endmodule
`default_nettype wire
